// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage hazard request / pipeline control bundle.
//   master : the pipeline (id_stage side) drives instruction info, receives controls.
//   slave  : hazard_ctrl receives instruction info, drives stall/flush/freeze,
//            forwarding selects and the lost-cycle counter.
interface hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_ra_addr;
  logic [4:0]  id_rb_addr;
  logic        id_uses_ra;
  logic        id_uses_rb;
  logic [4:0]  id_rd_addr;
  logic        id_writes_rd;
  logic        id_is_load;
  logic        ex_branch_taken;
  logic        mem_busy;
  logic        pc_stall;
  logic        if_flush;
  logic        id_bubble;
  logic        pipe_freeze;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [15:0] stall_count;

  modport master (
    output id_valid, id_ra_addr, id_rb_addr, id_uses_ra, id_uses_rb,
    output id_rd_addr, id_writes_rd, id_is_load, ex_branch_taken, mem_busy,
    input  pc_stall, if_flush, id_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_ra_addr, id_rb_addr, id_uses_ra, id_uses_rb,
    input  id_rd_addr, id_writes_rd, id_is_load, ex_branch_taken, mem_busy,
    output pc_stall, if_flush, id_bubble, pipe_freeze, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the five-stage core.
// Tracks destination registers in EX/MEM/WB and derives load-use stalls,
// branch flushes, memory-wait freezes, registered forwarding selects and a
// saturating lost-cycle counter.
// Ports:
//   clk   - core clock
//   rst_n - active-low asynchronous reset
//   io_hz - hazard_ctrl_if.slave: ID instruction info in, pipeline controls out
module hazard_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  io_hz
);

  // Scoreboard slots. is_load only matters in EX (load-use detection).
  logic       r_ex_vld;
  logic [4:0] r_ex_rd;
  logic       r_ex_ld;
  logic       r_mem_vld;
  logic [4:0] r_mem_rd;
  logic       r_wb_vld;
  logic [4:0] r_wb_rd;

  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic [15:0] r_stall_cnt;

  logic       w_load_use;
  logic       w_pc_stall;
  logic       w_if_flush;
  logic       w_id_bubble;
  logic       w_pipe_freeze;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  function automatic logic f_writes(input logic vld, input logic [4:0] rd, input logic [4:0] r);
    return vld && (rd == r) && (r != 5'd0);
  endfunction

  // Youngest producer wins; a load in EX cannot be forwarded from EX/MEM.
  function automatic logic [1:0] f_sel(input logic uses, input logic [4:0] r);
    logic [1:0] sel;
    sel = 2'd0;
    if (uses) begin
      if (f_writes(r_ex_vld, r_ex_rd, r) && !r_ex_ld) sel = 2'd1;
      else if (f_writes(r_mem_vld, r_mem_rd, r))     sel = 2'd2;
      else if (f_writes(r_wb_vld, r_wb_rd, r))       sel = 2'd3;
    end
    return sel;
  endfunction

  assign w_load_use = io_hz.id_valid && r_ex_ld &&
                      ((io_hz.id_uses_ra && f_writes(r_ex_vld, r_ex_rd, io_hz.id_ra_addr)) ||
                       (io_hz.id_uses_rb && f_writes(r_ex_vld, r_ex_rd, io_hz.id_rb_addr)));

  // Priority: memory freeze > taken branch > load-use.
  always_comb begin
    w_pc_stall    = 1'b0;
    w_if_flush    = 1'b0;
    w_id_bubble   = 1'b0;
    w_pipe_freeze = 1'b0;
    if (io_hz.mem_busy) begin
      w_pipe_freeze = 1'b1;
      w_pc_stall    = 1'b1;
    end else if (io_hz.ex_branch_taken) begin
      w_if_flush  = 1'b1;
      w_id_bubble = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall  = 1'b1;
      w_id_bubble = 1'b1;
    end
  end

  always_comb begin
    w_fwd_a = 2'd0;
    w_fwd_b = 2'd0;
    if (!w_id_bubble) begin
      w_fwd_a = f_sel(io_hz.id_uses_ra, io_hz.id_ra_addr);
      w_fwd_b = f_sel(io_hz.id_uses_rb, io_hz.id_rb_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_vld  <= 1'b0;
      r_ex_rd   <= 5'd0;
      r_ex_ld   <= 1'b0;
      r_mem_vld <= 1'b0;
      r_mem_rd  <= 5'd0;
      r_wb_vld  <= 1'b0;
      r_wb_rd   <= 5'd0;
      r_fwd_a   <= 2'd0;
      r_fwd_b   <= 2'd0;
    end else if (!io_hz.mem_busy) begin
      r_wb_vld  <= r_mem_vld;
      r_wb_rd   <= r_mem_rd;
      r_mem_vld <= r_ex_vld;
      r_mem_rd  <= r_ex_rd;
      r_ex_vld  <= !w_id_bubble && io_hz.id_valid && io_hz.id_writes_rd;
      r_ex_rd   <= io_hz.id_rd_addr;
      r_ex_ld   <= io_hz.id_is_load;
      r_fwd_a   <= w_fwd_a;
      r_fwd_b   <= w_fwd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if ((w_pc_stall || w_pipe_freeze) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign io_hz.pc_stall    = w_pc_stall;
  assign io_hz.if_flush    = w_if_flush;
  assign io_hz.id_bubble   = w_id_bubble;
  assign io_hz.pipe_freeze = w_pipe_freeze;
  assign io_hz.fwd_a_sel   = r_fwd_a;
  assign io_hz.fwd_b_sel   = r_fwd_b;
  assign io_hz.stall_count = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the MINA2000 five-stage core (IF, ID, EX, MEM, WB). It keeps a shadow scoreboard of the destination registers in EX, MEM and WB, and uses it to make three kinds of decision each cycle:
- load-use stalls and forwarding selects for the instruction in ID;
- flushes on a taken branch;
- a full-pipeline freeze while data memory is busy.

It also counts lost cycles. It sits beside `id_stage` and drives the enables and bubbles of the IF/ID and ID/EX pipeline registers.

## Interface
- No parameters. Register addresses are fixed at 5 bits; the performance counter is fixed at 16 bits.
- `clk`  in  1  core clock.
- `rst_n`  in  1  active-low reset, asynchronous assert; sole clock `clk`.
- `id_valid`  in  1  ID holds a real instruction, not a bubble.
- `id_ra_addr`, `id_rb_addr`  in  5 each  source registers of the instruction in ID.
- `id_uses_ra`, `id_uses_rb`  in  1 each  the instruction in ID actually reads that source.
- `id_rd_addr`  in  5  destination register of the instruction in ID.
- `id_writes_rd`  in  1  the instruction in ID writes `id_rd_addr`; low for stores and plain branches.
- `id_is_load`  in  1  the instruction in ID is `MEM_OP_LOAD`.
- `ex_branch_taken`  in  1  the branch in EX resolved taken this cycle.
- `mem_busy`  in  1  data memory has not completed the access in MEM.
- `pc_stall`  out  1  hold the PC and IF/ID.
- `if_flush`  out  1  load a bubble into IF/ID.
- `id_bubble`  out  1  load a bubble into ID/EX.
- `pipe_freeze`  out  1  hold every pipeline register.
- `fwd_a_sel`, `fwd_b_sel`  out  2 each  registered; operand source for the instruction now in EX:
  - 0: regfile;
  - 1: EX/MEM result;
  - 2: MEM/WB result;
  - 3: retired-value latch, i.e. the WB result of the previous cycle.
- `stall_count`  out  16  saturating count of cycles in which `pc_stall` or `pipe_freeze` was high.

## Operation
- **Scoreboard.** Three slots: `S_EX`, `S_MEM`, `S_WB`. Each slot holds {valid, rd, is_load}. A slot "writes r" when valid=1, rd=r and r≠0; r0 never produces a hazard.
- **Hazard.** A source r of the ID instruction is hazardous when `id_valid`, the matching `id_uses_*` is high, and the source matches.
  - Load-use: `S_EX` writes r and `S_EX.is_load`=1.
- **Priority** (highest first):
  1. `mem_busy`: `pipe_freeze`=1 and `pc_stall`=1; `if_flush`=0 and `id_bubble`=0; scoreboard and fwd selects hold; `ex_branch_taken` is ignored.
  2. `ex_branch_taken`: `if_flush`=1 and `id_bubble`=1; `pc_stall`=0; a pending load-use is discarded.
  3. Load-use: `pc_stall`=1 and `id_bubble`=1.
  4. Otherwise all four control outputs are 0.
- **Advance** (every cycle with `mem_busy`=0):
  - `S_WB` ← `S_MEM`, `S_MEM` ← `S_EX`.
  - `S_EX` ← {`id_valid & id_writes_rd`, `id_rd_addr`, `id_is_load`} if `id_bubble`=0, else invalid.
- **Forward select** (per operand, registered on advance; forced to 0 when `id_bubble`=1 or the operand is unused), youngest match wins:
  - `S_EX` writes r (non-load) → 1;
  - else `S_MEM` writes r → 2;
  - else `S_WB` writes r → 3;
  - else 0.
- **`stall_count`**: increments by 1 per stall or freeze cycle; holds at 16'hFFFF once reached.

## Timing
- All control outputs are combinational from the scoreboard and the inputs. Fwd selects and `stall_count` are registered.
- **Reset** (async, `rst_n`=0): all slots invalid; `fwd_*_sel`=0; `stall_count`=0. Combinational outputs follow from the cleared state: all 0, except `pipe_freeze`/`pc_stall`, which follow `mem_busy`.
- **Load-use penalty:** exactly 1 cycle. The bubble enters `S_EX` and the next cycle the consumer sees the load in `S_MEM` → sel 2.
- **Branch penalty:** 2 instructions (IF/ID and ID) are squashed in the resolution cycle.
- **Long memory wait:** any `mem_busy` duration freezes state exactly. The cycle after `mem_busy` falls behaves as if the frozen cycles never occurred.
- **Branch during freeze:** a taken branch held in EX during a freeze takes effect on the first unfrozen cycle.

## Test plan
- **Back-to-back ALU dependency.** Stimulus: `add r3` then `sub r4,r3,r3`. Required: no stall; `fwd_a_sel`=`fwd_b_sel`=1 with `sub` in EX.
- **Load-use.** Stimulus: `load r5` then `add r6,r5,r0`. Required:
  - 1 cycle with `pc_stall`=1 and `id_bubble`=1;
  - then `fwd_a_sel`=2 and `fwd_b_sel`=0;
  - `stall_count`=1.
- **r0 and unused operands.** Stimulus: `load r0` then a reader of r0; also a U-type instruction with `id_uses_ra`=0 whose ra field matches a pending rd. Required: no stall and sel 0 in both cases.
- **Branch versus load-use.** Stimulus: `ex_branch_taken`=1 in the same cycle as a load-use hazard. Required:
  - `if_flush`=1, `id_bubble`=1, `pc_stall`=0;
  - `stall_count` unchanged.
- **Memory freeze.** Stimulus: `mem_busy` high for 4 cycles, with a taken branch in EX. Required:
  - `pipe_freeze`=1 for 4 cycles and `if_flush`=0 throughout;
  - flush on the 5th cycle;
  - `stall_count`+=4;
  - scoreboard and fwd selects unchanged across the freeze.
- **Saturation and reset.**
  - Hold `mem_busy` for 70000 cycles: `stall_count` holds at 16'hFFFF.
  - Assert `rst_n` low mid-freeze: all registered state clears immediately, without waiting for a clock edge.
